// File: rtl/onchip_mem_stream_reader.sv
// onchip_mem_stream_reader
//   Reads a block of words from an on-chip memory with fixed read latency 1
//   and emits them as a stream with first-word-fall-through buffering,
//   start/end-of-packet markers and sink backpressure.
// Ports:
//   clk, reset        single clock, synchronous active-high reset
//   start             one-cycle transfer request (ignored while busy)
//   base_addr         first word address, sampled on accepted start
//   word_count        number of words (0..2^ADDR_W), sampled on accepted start
//   busy, done        transfer in progress / one-cycle completion pulse
//   m_address         memory word address
//   m_chipselect      read request qualifier
//   m_write, m_byteenable, m_clken   constant read-only controls
//   m_readdata        memory read data, valid one cycle after chipselect
//   st_data, st_valid, st_ready, st_sop, st_eop   output stream
module onchip_mem_stream_reader #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W:0]       word_count,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W-1:0]     m_address,
  output logic                  m_chipselect,
  output logic                  m_write,
  output logic [DATA_W/8-1:0]   m_byteenable,
  output logic                  m_clken,
  input  logic [DATA_W-1:0]     m_readdata,
  output logic [DATA_W-1:0]     st_data,
  output logic                  st_valid,
  input  logic                  st_ready,
  output logic                  st_sop,
  output logic                  st_eop
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned EW = DATA_W + 2;
  localparam logic [CW:0]     DEPTH_L = (CW + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_W:0] ONE_W   = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W:0]     left_q;
  logic [ADDR_W:0]     total_q;
  logic                infl_q, infl_sop_q, infl_eop_q;
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       cnt_q;
  logic [EW-1:0]       fifo_q [FIFO_DEPTH];
  logic [EW-1:0]       head;
  logic [CW:0]         occ;
  logic                rd_en, push, pop, accept;

  // Reads in flight count against capacity so returning data always fits.
  assign occ    = {1'b0, cnt_q} + {{CW{1'b0}}, infl_q};
  assign rd_en  = (state_q == READ) && (left_q != '0) && (occ < DEPTH_L);
  assign push   = infl_q;
  assign pop    = st_valid && st_ready;
  assign accept = (state_q == IDLE) && start;

  assign head     = fifo_q[rd_ptr_q];
  assign st_valid = (cnt_q != '0);
  assign st_data  = head[DATA_W-1:0];
  assign st_sop   = st_valid && head[DATA_W];
  assign st_eop   = st_valid && head[DATA_W+1];

  assign m_address    = addr_q;
  assign m_chipselect = rd_en;
  assign m_write      = 1'b0;
  assign m_byteenable = '1;
  assign m_clken      = 1'b1;

  assign busy = (state_q == READ) || (state_q == DRAIN);
  assign done = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (word_count == '0) ? DONE : READ;
      READ:    if (rd_en && (left_q == ONE_W)) state_d = DRAIN;
      DRAIN:   if (pop && st_eop) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      left_q     <= '0;
      total_q    <= '0;
      infl_q     <= 1'b0;
      infl_sop_q <= 1'b0;
      infl_eop_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      state_q <= state_d;
      if (accept && (word_count != '0)) begin
        addr_q  <= base_addr;
        left_q  <= word_count;
        total_q <= word_count;
      end else if (rd_en) begin
        addr_q <= addr_q + ADDR_W'(1);
        left_q <= left_q - ONE_W;
      end
      // Packet markers travel with the read so they land beside their data.
      infl_q     <= rd_en;
      infl_sop_q <= rd_en && (left_q == total_q);
      infl_eop_q <= rd_en && (left_q == ONE_W);
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= {infl_eop_q, infl_sop_q, m_readdata};
  end

endmodule

// File: tb/tb_onchip_mem_stream_reader.sv
module tb_onchip_mem_stream_reader;

  logic        clk = 1'b0;
  logic        reset, start, st_ready;
  logic [9:0]  base_addr;
  logic [10:0] word_count;
  logic        busy, done, m_chipselect, m_write, m_clken;
  logic [9:0]  m_address;
  logic [3:0]  m_byteenable;
  logic [31:0] m_readdata, st_data;
  logic        st_valid, st_sop, st_eop;

  int checks = 0, failures = 0, cyc = 0;
  int rdy_mode = 1;
  logic [33:0] exp_q[$];
  logic [9:0]  addr_q[$];
  int cs_cnt = 0, val_cnt = 0, acc_cnt = 0, done_cnt = 0;
  int cs_first = 0, val_first = 0, sop_cyc = 0, eop_cyc = 0;
  bit cs_seen = 0, val_seen = 0, prev_stall = 0;
  logic [33:0] prev_word = '0;

  onchip_mem_stream_reader #(.ADDR_W(10), .DATA_W(32), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .word_count(word_count), .busy(busy), .done(done), .m_address(m_address),
    .m_chipselect(m_chipselect), .m_write(m_write), .m_byteenable(m_byteenable),
    .m_clken(m_clken), .m_readdata(m_readdata), .st_data(st_data),
    .st_valid(st_valid), .st_ready(st_ready), .st_sop(st_sop), .st_eop(st_eop));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] memf(input logic [9:0] a);
    return {a, 6'h2B, a, 6'h1D};
  endfunction

  // Memory with one-cycle read latency; garbage when not selected.
  always @(posedge clk) m_readdata <= m_chipselect ? memf(m_address) : 32'hDEAD_BEEF;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endfunction

  initial begin
    st_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       st_ready = 1'b0;
        2:       st_ready = 1'($urandom_range(0, 1));
        default: st_ready = 1'b1;
      endcase
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 0;
    end else begin
      if (m_chipselect) begin
        cs_cnt++;
        if (!cs_seen) begin cs_seen = 1; cs_first = cyc; end
        check("rd_addr_expected", addr_q.size() != 0, 1);
        if (addr_q.size() != 0) check("rd_addr", m_address, addr_q.pop_front());
      end
      if (prev_stall) check("st_hold", {st_valid, st_eop, st_sop, st_data}, {1'b1, prev_word});
      if (st_valid) begin
        val_cnt++;
        if (!val_seen) begin val_seen = 1; val_first = cyc; end
        if (st_ready) begin
          acc_cnt++;
          check("st_word_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) check("st_word", {st_eop, st_sop, st_data}, exp_q.pop_front());
          if (st_sop) sop_cyc = cyc;
          if (st_eop) eop_cyc = cyc;
        end
      end
      prev_stall = st_valid && !st_ready;
      prev_word  = {st_eop, st_sop, st_data};
      if (done) done_cnt++;
    end
  end

  task automatic push_xfer(input logic [9:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      logic [9:0] a;
      a = base + 10'(i);
      exp_q.push_back({i == n - 1, i == 0, memf(a)});
      addr_q.push_back(a);
    end
  endtask

  task automatic do_start(input logic [9:0] base, input int n);
    cs_seen = 0; val_seen = 0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = base; word_count = 11'(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int dcyc);
    dcyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        dcyc = cyc;
        check("busy_at_done", busy, 0);
        break;
      end
    end
    check("done_seen", dcyc >= 0, 1);
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_words_left"}, exp_q.size(), 0);
    check({tag, "_reads_left"}, addr_q.size(), 0);
  endtask

  initial begin
    int d, c0, v0, a0, n0;
    reset = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outs", {busy, done, m_chipselect, m_address, st_valid, st_sop, st_eop}, '0);
    check("tie_offs", {m_write, m_byteenable, m_clken}, {1'b0, 4'hF, 1'b1});
    @(posedge clk); #1; reset = 1'b0;

    // Basic block, full throughput
    rdy_mode = 1;
    push_xfer(10'h010, 4);
    c0 = cs_cnt;
    do_start(10'h010, 4);
    wait_done(50, d);
    check("t1_reads", cs_cnt - c0, 4);
    check("t1_latency", val_first - cs_first, 2);
    check("t1_back_to_back", eop_cyc - sop_cyc, 3);
    check("t1_done_after_eop", d - eop_cyc, 1);
    check_drained("t1");

    // Address wrap
    push_xfer(10'h3FE, 4);
    do_start(10'h3FE, 4);
    wait_done(50, d);
    check_drained("t2");

    // Zero-length transfer
    c0 = cs_cnt; v0 = val_cnt;
    do_start(10'h123, 0);
    wait_done(10, d);
    check("t3_no_reads", cs_cnt - c0, 0);
    check("t3_no_words", val_cnt - v0, 0);

    // Stalled sink: only FIFO_DEPTH reads may be issued
    rdy_mode = 0;
    push_xfer(10'h040, 16);
    do_start(10'h040, 16);
    c0 = cs_cnt;
    repeat (20) @(negedge clk);
    check("t4_reads_in_stall", cs_cnt - c0, 4);
    rdy_mode = 1;
    wait_done(200, d);
    check("t4_reads_total", cs_cnt - c0, 16);
    check_drained("t4");

    // Full-size block, random backpressure, start while busy ignored
    rdy_mode = 2;
    push_xfer(10'h155, 1024);
    a0 = acc_cnt;
    do_start(10'h155, 1024);
    repeat (50) @(posedge clk);
    #1; start = 1'b1; base_addr = 10'h000; word_count = 11'd3;
    @(posedge clk); #1; start = 1'b0;
    wait_done(20000, d);
    check("t5_words", acc_cnt - a0, 1024);
    check_drained("t5");

    // Reset mid-transfer
    rdy_mode = 1;
    push_xfer(10'h020, 10);
    a0 = acc_cnt;
    do_start(10'h020, 10);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (acc_cnt - a0 >= 5) break;
    end
    check("t6_reached_word5", acc_cnt - a0 >= 5, 1);
    n0 = done_cnt;
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    exp_q.delete(); addr_q.delete();
    @(negedge clk);
    check("t6_reset_outs", {busy, done, m_chipselect, m_address, st_valid, st_sop, st_eop}, '0);
    @(negedge clk);
    check("t6_late_read_dropped", {st_valid, busy}, 2'b00);
    repeat (5) @(negedge clk);
    check("t6_no_done", done_cnt - n0, 0);
    push_xfer(10'h3FF, 3);
    do_start(10'h3FF, 3);
    wait_done(50, d);
    check_drained("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
